// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider: S = A / B, R = A % B, one quotient bit per clock.
// Optional two's-complement mode divides magnitudes and fixes signs on the final step.
module divisor_secuencial #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg, b_neg, b_zero, accept, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quot_step, q_final, r_final;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return '0 - x;
  endfunction

  always_comb begin
    a_neg     = (SIGNED != 0) && A[WIDTH-1];
    b_neg     = (SIGNED != 0) && B[WIDTH-1];
    a_mag     = a_neg ? neg(A) : A;
    b_mag     = b_neg ? neg(B) : B;
    b_zero    = (B == '0);
    accept    = start && (state != CALC);
    last      = (state == CALC) && (cnt == '0);
    // Shift in the next dividend bit; the subtraction borrow decides the quotient bit.
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_q};
    fits      = ~diff[WIDTH];
    rem_step  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], fits};
    q_final   = neg_q ? neg(quot_step) : quot_step;
    r_final   = neg_r ? neg(rem_step) : rem_step;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = b_zero ? FIN : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_next = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) state_next = b_zero ? FIN : CALC;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      S        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else begin
      if (accept && !b_zero) begin
        dvd_q  <= a_mag;
        dvs_q  <= b_mag;
        rem_q  <= '0;
        quot_q <= '0;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        cnt    <= CNT_INIT;
      end else if (state == CALC) begin
        rem_q  <= rem_step;
        quot_q <= quot_step;
        dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
        cnt    <= cnt - 1'b1;
      end

      // Results are written only on the edge that enters FIN.
      if (accept && b_zero) begin
        S        <= '1;
        R        <= A;
        div_zero <= 1'b1;
      end else if (last) begin
        S        <= q_final;
        R        <= r_final;
        div_zero <= 1'b0;
      end
    end
  end

endmodule
